// File: rtl/bt656_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bt656_pkg
// Description : Shared types and defaults for the BT.656 capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bt656_pkg;

    localparam int DEF_H_ACTIVE = 720;
    localparam int DEF_V_LINES  = 244;
    localparam int PIX_DATA_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_CAP0  = 3'd2,
        ST_CAP1  = 3'd3,
        ST_DRAIN = 3'd4
    } cap_state_t;

    // Bits needed to hold every value from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bt656_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bt656_capture_ctrl_if
// Description : Pixel write port towards frame memory (request/ack handshake).
// Revision    : 1.0 - initial release
// ============================================================================
interface bt656_capture_ctrl_if
    import bt656_pkg::*;
#(
    parameter int ADDR_W = 19
);
    logic                  wr_req;
    logic [ADDR_W-1:0]     wr_addr;
    logic [PIX_DATA_W-1:0] wr_data;
    logic                  wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input  wr_ack);
    modport slave  (input  wr_req, input  wr_addr, input  wr_data, output wr_ack);
endinterface
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : capture_fifo
// Description : Small count-based write buffer; simultaneous push and pop are
//               both honoured even when full. Head reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bt656_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bt656_capture_ctrl
// Description : Captures one (or continuous) interlaced frames from a BT.656
//               decoder into a linear frame buffer; field 0 lines land on even
//               line slots, field 1 lines on odd slots.
// Revision    : 1.0 - initial release
// ============================================================================
module bt656_capture_ctrl
    import bt656_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_LINES    = DEF_V_LINES,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  TD_CLK_27,
    input  logic                  reset,
    input  logic [PIX_DATA_W-1:0] YCbCr,
    input  logic                  Data_Valid,
    input  logic                  field,
    input  logic                  active_video,
    input  logic                  start,
    input  logic                  continuous,
    bt656_capture_ctrl_if.master  wr,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [7:0]            frame_count
);
    localparam int PIX_CW  = cnt_width(H_ACTIVE);
    localparam int LINE_CW = cnt_width(V_LINES);
    localparam int ENTRY_W = ADDR_W + PIX_DATA_W;

    localparam logic [PIX_CW-1:0]  PIX_LIM   = PIX_CW'(H_ACTIVE);
    localparam logic [LINE_CW-1:0] LINE_LIM  = LINE_CW'(V_LINES);
    localparam logic [ADDR_W-1:0]  FIELD_OFS = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0]  LINE_STEP = ADDR_W'(2 * H_ACTIVE);

    cap_state_t         state;
    logic               field_d;
    logic               av_d;
    logic [PIX_CW-1:0]  pix_cnt;
    logic [LINE_CW-1:0] line_cnt;
    logic [ADDR_W-1:0]  line_base;

    logic               field_fall;
    logic               field_rise;
    logic               field_edge;
    logic               av_fall;
    logic               capturing;
    logic               strobe;
    logic               in_range;
    logic               push;
    logic               pop;
    logic               overflow_evt;
    logic [ADDR_W-1:0]  cap_addr;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    logic               fifo_full;

    assign field_fall = field_d & ~field;
    assign field_rise = ~field_d & field;
    assign field_edge = field_d ^ field;
    assign av_fall    = av_d & ~active_video;

    // Strobes coinciding with a field edge belong to neither field and are ignored.
    assign capturing  = (state == ST_CAP0) || (state == ST_CAP1);
    assign strobe     = capturing & Data_Valid & ~field_edge;
    assign in_range   = (pix_cnt < PIX_LIM) && (line_cnt < LINE_LIM);
    assign push       = strobe & in_range;
    assign pop        = wr.wr_req & wr.wr_ack;
    // A pop in the same cycle frees the slot, so only an unpaired push when full is lost.
    assign overflow_evt = push & fifo_full & ~pop;

    // Interleaved address: line_base already holds 2*line*H_ACTIVE.
    assign cap_addr = line_base + ((state == ST_CAP1) ? FIELD_OFS : '0) + ADDR_W'(pix_cnt);

    assign wr.wr_req = ~fifo_empty;
    assign {wr.wr_addr, wr.wr_data} = fifo_head;
    assign busy = (state != ST_IDLE) | ~fifo_empty;

    capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (TD_CLK_27),
        .rst_n     (reset),
        .push      (push),
        .push_data ({cap_addr, YCbCr}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Previous-cycle copies of the decoder flags for edge detection.
    always_ff @(posedge TD_CLK_27 or negedge reset) begin
        if (!reset) begin
            field_d <= 1'b0;
            av_d    <= 1'b0;
        end else begin
            field_d <= field;
            av_d    <= active_video;
        end
    end

    // Pixel/line position tracking; counters saturate at their limits so late strobes stay out of range.
    always_ff @(posedge TD_CLK_27 or negedge reset) begin
        if (!reset) begin
            pix_cnt   <= '0;
            line_cnt  <= '0;
            line_base <= '0;
        end else if (field_edge) begin
            pix_cnt   <= '0;
            line_cnt  <= '0;
            line_base <= '0;
        end else if (av_fall) begin
            pix_cnt <= '0;
            if ((pix_cnt != '0) && (line_cnt < LINE_LIM)) begin
                line_cnt  <= line_cnt + LINE_CW'(1);
                line_base <= line_base + LINE_STEP;
            end
        end else if (strobe && (pix_cnt < PIX_LIM)) begin
            pix_cnt <= pix_cnt + PIX_CW'(1);
        end
    end

    // Capture sequencing plus frame/overflow status.
    always_ff @(posedge TD_CLK_27 or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            overflow    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SYNC;
                        overflow <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (field_fall) state <= ST_CAP0;
                end
                ST_CAP0: begin
                    if (field_rise) state <= ST_CAP1;
                end
                ST_CAP1: begin
                    if (field_fall) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        state       <= continuous ? ST_CAP0 : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (overflow_evt) overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bt656_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt656_capture_ctrl
// Description : Directed, self-checking bench for bt656_capture_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bt656_capture_ctrl;
    import bt656_pkg::*;

    localparam int ADDR_W = 19;
    localparam int H      = 720;
    localparam int NVEC   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ycbcr;
    logic        dv, fld, av, start, cont;
    logic        busy, frame_done, overflow;
    logic [7:0]  frame_count;

    bt656_capture_ctrl_if #(.ADDR_W(ADDR_W)) wr_bus ();

    bt656_capture_ctrl #(
        .H_ACTIVE   (H),
        .V_LINES    (244),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (4)
    ) dut (
        .TD_CLK_27    (clk),
        .reset        (reset),
        .YCbCr        (ycbcr),
        .Data_Valid   (dv),
        .field        (fld),
        .active_video (av),
        .start        (start),
        .continuous   (cont),
        .wr           (wr_bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int seq    = 0;
    int busy_low_cnt = 0;
    logic [ADDR_W-1:0] log_addr [$];
    logic [15:0]       log_data [$];

    // Write monitor: a word is accepted whenever req and ack are both high before the edge.
    always @(negedge clk) begin
        if (reset && wr_bus.wr_req && wr_bus.wr_ack) begin
            log_addr.push_back(wr_bus.wr_addr);
            log_data.push_back(wr_bus.wr_data);
        end
        if (!busy) busy_low_cnt = busy_low_cnt + 1;
    end

    typedef struct {
        logic [4:0]  ctl;   // {start, field, active_video, Data_Valid, wr_ack}
        logic [15:0] din;
        logic [37:0] exp;   // {wr_req, wr_addr, wr_data, busy, overflow}
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [37:0] ex(input int r, input int a, input int d, input int b, input int o);
        return {r[0], 19'(a), 16'(d), b[0], o[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; dv = 1'b0; av = 1'b0; fld = 1'b0;
        cont = 1'b0; ycbcr = 16'd0; wr_bus.wr_ack = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic set_field(input logic v);
        fld = v; step(); step();
    endtask

    task automatic drive_line(input int n);
        av = 1'b1;
        for (int i = 0; i < n; i++) begin
            dv = 1'b1; ycbcr = 16'(seq); seq++;
            step();
        end
        dv = 1'b0; av = 1'b0;
        step(); step();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin step(); n++; end
        check(name, 64'(busy), 64'(0));
    endtask

    function automatic int exp_frame_addr(input int k);
        int off = k % H;
        case (k / H)
            0:       return off;
            1:       return 2 * H + off;
            2:       return H + off;
            default: return 3 * H + off;
        endcase
    endfunction

    initial begin
        int base, bad, bad_d, seq0, b0;

        // Cycle-by-cycle table: arm, sync on field fall, fill FIFO, full push+pop, overflow, drain.
        vecs[0]  = '{5'b00000, 16'h0000, ex(0, 0, 0,       0, 0)};
        vecs[1]  = '{5'b10000, 16'h0000, ex(0, 0, 0,       1, 0)};
        vecs[2]  = '{5'b01000, 16'h0000, ex(0, 0, 0,       1, 0)};
        vecs[3]  = '{5'b01000, 16'h0000, ex(0, 0, 0,       1, 0)};
        vecs[4]  = '{5'b00000, 16'h0000, ex(0, 0, 0,       1, 0)};
        vecs[5]  = '{5'b00110, 16'hA001, ex(1, 0, 'hA001, 1, 0)};
        vecs[6]  = '{5'b00100, 16'h0000, ex(1, 0, 'hA001, 1, 0)};
        vecs[7]  = '{5'b00110, 16'hA002, ex(1, 0, 'hA001, 1, 0)};
        vecs[8]  = '{5'b00110, 16'hA003, ex(1, 0, 'hA001, 1, 0)};
        vecs[9]  = '{5'b00110, 16'hA004, ex(1, 0, 'hA001, 1, 0)};
        vecs[10] = '{5'b00111, 16'hA005, ex(1, 1, 'hA002, 1, 0)};
        vecs[11] = '{5'b00110, 16'hA006, ex(1, 1, 'hA002, 1, 1)};
        vecs[12] = '{5'b00101, 16'h0000, ex(1, 2, 'hA003, 1, 1)};
        vecs[13] = '{5'b00101, 16'h0000, ex(1, 3, 'hA004, 1, 1)};
        vecs[14] = '{5'b00101, 16'h0000, ex(1, 4, 'hA005, 1, 1)};
        vecs[15] = '{5'b00101, 16'h0000, ex(0, 0, 0,       1, 1)};

        // Reset state
        do_reset();
        check("reset_outputs",
              64'({wr_bus.wr_req, wr_bus.wr_addr, wr_bus.wr_data, busy, frame_done, overflow, frame_count}),
              64'(0));

        for (int i = 0; i < NVEC; i++) begin
            {start, fld, av, dv, wr_bus.wr_ack} = vecs[i].ctl;
            ycbcr = vecs[i].din;
            step();
            check($sformatf("vec%0d", i),
                  64'({wr_bus.wr_req, wr_bus.wr_addr, wr_bus.wr_data, busy, overflow}),
                  64'(vecs[i].exp));
        end

        // Finish the frame: overflow stays sticky, the next start clears it.
        start = 1'b0; av = 1'b0; dv = 1'b0; wr_bus.wr_ack = 1'b1;
        step(); step();
        set_field(1'b1);
        set_field(1'b0);
        wait_idle("ovf_frame_idle");
        check("ovf_sticky", 64'(overflow), 64'(1));
        pulse_start();
        check("start_clears_ovf", 64'(overflow), 64'(0));

        // Full frame: 2 lines per field, ack tied high.
        do_reset();
        wr_bus.wr_ack = 1'b1;
        pulse_start();
        set_field(1'b1);
        set_field(1'b0);
        base = log_addr.size();
        seq0 = seq;
        drive_line(H); drive_line(H);
        set_field(1'b1);
        drive_line(H); drive_line(H);
        fld = 1'b0;
        step();
        check("frame_done_pulse", 64'(frame_done), 64'(1));
        check("frame_count_1", 64'(frame_count), 64'(1));
        step();
        check("frame_done_clear", 64'(frame_done), 64'(0));
        wait_idle("frame_idle");
        check("frame_writes", 64'(log_addr.size() - base), 64'(4 * H));
        bad = 0; bad_d = 0;
        for (int k = 0; k < 4 * H && base + k < log_addr.size(); k++) begin
            if (int'(log_addr[base + k]) != exp_frame_addr(k)) bad++;
            if (log_data[base + k] != 16'(seq0 + k)) bad_d++;
        end
        check("frame_addr_seq", 64'(bad), 64'(0));
        check("frame_data_seq", 64'(bad_d), 64'(0));
        if (log_addr.size() > base + 2 * H)
            check("field1_line0_addr", 64'(log_addr[base + 2 * H]), 64'(H));

        // Over-long line: only the first H_ACTIVE pixels are written.
        do_reset();
        wr_bus.wr_ack = 1'b1;
        pulse_start();
        set_field(1'b1);
        set_field(1'b0);
        base = log_addr.size();
        drive_line(H + 10);
        step(); step(); step();
        check("long_line_writes", 64'(log_addr.size() - base), 64'(H));
        bad = 0;
        for (int k = 0; base + k < log_addr.size(); k++)
            if (int'(log_addr[base + k]) != k) bad++;
        check("long_line_addrs", 64'(bad), 64'(0));

        // Start mid field 0: nothing captured until the next field 1->0 edge.
        do_reset();
        wr_bus.wr_ack = 1'b1;
        set_field(1'b1);
        set_field(1'b0);
        pulse_start();
        base = log_addr.size();
        drive_line(10);
        set_field(1'b1);
        drive_line(5);
        step(); step();
        check("sync_no_writes", 64'(log_addr.size() - base), 64'(0));
        set_field(1'b0);
        drive_line(3);
        step(); step();
        check("sync_then_writes", 64'(log_addr.size() - base), 64'(3));
        if (log_addr.size() == base + 3)
            check("sync_last_addr", 64'(log_addr[base + 2]), 64'(2));

        // Continuous: two back-to-back frames, then continuous drops mid-frame.
        do_reset();
        wr_bus.wr_ack = 1'b1;
        cont = 1'b1;
        pulse_start();
        b0 = busy_low_cnt;
        set_field(1'b1);
        set_field(1'b0);
        base = log_addr.size();
        drive_line(4);
        set_field(1'b1);
        drive_line(4);
        fld = 1'b0; step();
        check("cont_count_1", 64'(frame_count), 64'(1));
        step();
        drive_line(4);
        set_field(1'b1);
        drive_line(4);
        fld = 1'b0; step();
        check("cont_count_2", 64'(frame_count), 64'(2));
        step();
        check("cont_never_idle", 64'(busy_low_cnt - b0), 64'(0));
        check("cont_writes", 64'(log_addr.size() - base), 64'(16));
        if (log_addr.size() >= base + 16) begin
            check("cont_f2_addr0", 64'(log_addr[base + 8]), 64'(0));
            check("cont_f2_field1", 64'(log_addr[base + 12]), 64'(H));
        end
        cont = 1'b0;
        set_field(1'b1);
        set_field(1'b0);
        wait_idle("cont_stop_idle");
        check("cont_count_3", 64'(frame_count), 64'(3));

        // frame_count wraps 255 -> 0.
        cont = 1'b1;
        pulse_start();
        set_field(1'b1);
        set_field(1'b0);
        for (int i = 0; i < 253; i++) begin
            set_field(1'b1);
            set_field(1'b0);
        end
        check("count_wrap_0", 64'(frame_count), 64'(0));
        cont = 1'b0;
        set_field(1'b1);
        set_field(1'b0);
        wait_idle("wrap_idle");
        check("count_after_wrap", 64'(frame_count), 64'(1));

        // Asynchronous reset mid-CAP1 with buffered words.
        pulse_start();
        set_field(1'b1);
        set_field(1'b0);
        set_field(1'b1);
        wr_bus.wr_ack = 1'b0;
        av = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dv = 1'b1; ycbcr = 16'h5A00 + 16'(i); step();
        end
        dv = 1'b0;
        check("pre_reset_req", 64'(wr_bus.wr_req), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({wr_bus.wr_req, wr_bus.wr_addr, wr_bus.wr_data, busy, frame_done, overflow, frame_count}),
              64'(0));
        av = 1'b0; wr_bus.wr_ack = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        base = log_addr.size();
        set_field(1'b1);
        set_field(1'b0);
        drive_line(5);
        step(); step();
        check("no_capture_without_start", 64'(log_addr.size() - base), 64'(0));
        check("idle_after_reset", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bt656_capture_ctrl.md
BT656_CAPTURE_CTRL -- requirements
Module: bt656_capture_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 720, meaning valid pixels stored per line.
REQ-002 SHALL have parameter V_LINES, default 244, meaning lines stored per field.
REQ-003 SHALL have parameter ADDR_W, default 19, meaning write address width (covers 2*V_LINES*H_ACTIVE).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning write-buffer entries (power of 2).
REQ-005 SHALL have port TD_CLK_27  in  1  27 MHz clock; the single clock of the block.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port YCbCr  in  16  decoder pixel {Y,C}.
REQ-008 SHALL have port Data_Valid  in  1  decoder pixel strobe.
REQ-009 SHALL have port field  in  1  decoder field flag (0 = field 0).
REQ-010 SHALL have port active_video  in  1  decoder active-line flag.
REQ-011 SHALL have port start  in  1  one-cycle capture request.
REQ-012 SHALL have port continuous  in  1  1 = re-arm after each frame.
REQ-013 SHALL have port wr_req  out  1  memory write request.
REQ-014 SHALL have port wr_addr  out  ADDR_W  pixel word address.
REQ-015 SHALL have port wr_data  out  16  pixel word.
REQ-016 SHALL have port wr_ack  in  1  memory accepts current word.
REQ-017 SHALL have ports busy out 1, frame_done out 1 (pulse), overflow out 1 (sticky), frame_count out 8.

Function
REQ-018 SHALL implement FSM IDLE, SYNC, CAP0, CAP1, DRAIN; busy = (state != IDLE) or FIFO not empty.
REQ-019 IDLE->SYNC on start; start outside IDLE SHALL be ignored; start SHALL clear overflow.
REQ-020 SYNC->CAP0 on field 1->0 edge (registered previous field); never on a level alone.
REQ-021 CAP0->CAP1 on field 0->1 edge; CAP1 on field 1->0 edge SHALL pulse frame_done one cycle, increment frame_count (wraps 255->0), go CAP0 if continuous else DRAIN.
REQ-022 DRAIN->IDLE when FIFO empty; continuous deasserted mid-frame SHALL finish the current frame.
REQ-023 Pixel counter SHALL count accepted Data_Valid strobes in CAP0/CAP1, clear on active_video falling edge and on every field edge.
REQ-024 Line counter SHALL increment on active_video falling edge only if pixel counter non-zero, clear on every field edge.
REQ-025 Address SHALL be (2*line + fieldbit)*H_ACTIVE + pixel, built from an accumulated line base (add 2*H_ACTIVE per line), no multiplier.
REQ-026 Strobes with pixel >= H_ACTIVE or line >= V_LINES SHALL be dropped silently (no push, no overflow).
REQ-027 Push {addr,data} into FIFO on accepted strobe; push when full with no pop SHALL drop the word and set overflow.
REQ-028 Push and pop in the same cycle when full SHALL both succeed; no overflow.
REQ-029 wr_req = FIFO not empty; wr_addr/wr_data = head entry, stable while wr_req and not wr_ack; pop on wr_req and wr_ack.
REQ-030 Latency strobe to wr_req with empty FIFO SHALL be 1 cycle.

Reset
REQ-031 reset low SHALL force IDLE, empty FIFO, counters 0, and wr_req, wr_addr, wr_data, busy, frame_done, overflow, frame_count to 0, immediately and asynchronously.
REQ-032 Reset mid-frame SHALL discard buffered words; first capture after reset requires a new start.

Structure
REQ-033 Package bt656_pkg SHALL hold the FSM state enum and H_ACTIVE/V_LINES defaults.
REQ-034 The FIFO SHALL be sub-module capture_fifo (parameterised width/depth, count-based full/empty).

Verification
REQ-035 start, then fields 1->0->1->0 with 2 lines x 720 strobes, wr_ack tied 1 -> 2880 writes, field-1 line 0 at address 720, one frame_done, frame_count=1, IDLE.
REQ-036 wr_ack 0 for 10 cycles with strobes every 2 cycles -> overflow=1 after 4 words buffered; start clears it.
REQ-037 Line of 730 strobes -> exactly 720 writes; addresses 0..719.
REQ-038 continuous=1 for two frames -> frame_count=2, state never IDLE between frames.
REQ-039 start while field=0 mid-field -> no writes until next field 1->0 edge.
REQ-040 reset asserted mid-CAP1 with 3 buffered words -> wr_req=0 same cycle, all outputs 0.
